// File: rtl/spi_ctrl.sv
// spi_ctrl: SPI initiator for the spi_mem protocol, single-byte read/write commands.
// Optional handshake watchdog is compiled in when SPI_CTRL_TIMEOUT_EN is defined.
module spi_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [4:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       err,
    output logic       cs,
    output logic       mosi,
    input  logic       ready,
    input  logic       miso,
    input  logic       op_done
);

    typedef enum logic [2:0] {IDLE, SEL, OPC, SHIFT, WAIT_RDY, RECV, WAIT_DONE} state_t;

    state_t      state, state_d;
    logic [15:0] sreg, sreg_d;
    logic [4:0]  bitcnt, bitcnt_d;
    logic        is_wr, is_wr_d;
    logic [7:0]  rxsh, rxsh_d, rdata_d;
    logic        cs_d, mosi_d, busy_d, done_d;

`ifdef SPI_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_d;
    logic          err_r, err_d, expired;

    assign expired = (tcnt == TW'(TIMEOUT - 1));
    assign err     = err_r;
`else
    assign err = 1'b0;
`endif

    // All outputs are registered; this block computes their next values.
    always_comb begin
        state_d  = state;
        sreg_d   = sreg;
        bitcnt_d = bitcnt;
        is_wr_d  = is_wr;
        rxsh_d   = rxsh;
        rdata_d  = rdata;
        cs_d     = cs;
        mosi_d   = mosi;
        busy_d   = busy;
        done_d   = 1'b0;
`ifdef SPI_CTRL_TIMEOUT_EN
        tcnt_d   = '0;
        err_d    = err_r;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    is_wr_d  = wr;
                    sreg_d   = {wdata, 3'b000, addr};
                    bitcnt_d = '0;
                    cs_d     = 1'b0;
                    mosi_d   = 1'b0;
                    busy_d   = 1'b1;
`ifdef SPI_CTRL_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = SEL;
                end
            end
            SEL: begin
                mosi_d  = is_wr;
                state_d = OPC;
            end
            OPC: begin
                mosi_d   = sreg[0];
                sreg_d   = sreg >> 1;
                bitcnt_d = 5'd1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                // cs rises on the edge after the last bit has been presented
                if (bitcnt == (is_wr ? 5'd16 : 5'd8)) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = is_wr ? WAIT_DONE : WAIT_RDY;
                end else begin
                    mosi_d   = sreg[0];
                    sreg_d   = sreg >> 1;
                    bitcnt_d = bitcnt + 5'd1;
                end
            end
            WAIT_RDY: begin
                if (ready) begin
                    bitcnt_d = '0;
                    state_d  = RECV;
                end
`ifdef SPI_CTRL_TIMEOUT_EN
                else if (expired) begin
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
`endif
            end
            RECV: begin
                rxsh_d   = {miso, rxsh[7:1]};
                bitcnt_d = bitcnt + 5'd1;
                if (bitcnt == 5'd7) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (op_done) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (!is_wr) rdata_d = rxsh;
                    state_d = IDLE;
                end
`ifdef SPI_CTRL_TIMEOUT_EN
                else if (expired) begin
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sreg   <= '0;
            bitcnt <= '0;
            is_wr  <= 1'b0;
            rxsh   <= '0;
            rdata  <= '0;
            cs     <= 1'b1;
            mosi   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SPI_CTRL_TIMEOUT_EN
            tcnt   <= '0;
            err_r  <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            sreg   <= sreg_d;
            bitcnt <= bitcnt_d;
            is_wr  <= is_wr_d;
            rxsh   <= rxsh_d;
            rdata  <= rdata_d;
            cs     <= cs_d;
            mosi   <= mosi_d;
            busy   <= busy_d;
            done   <= done_d;
`ifdef SPI_CTRL_TIMEOUT_EN
            tcnt   <= tcnt_d;
            err_r  <= err_d;
`endif
        end
    end

endmodule

// File: doc/spi_ctrl.md
# spi_ctrl

SPI initiator that drives the `spi_mem` serial protocol. It accepts single-byte read and write commands on a parallel request port. It serialises the opcode, address and data onto `cs`/`mosi`, and collects read data from `miso` using the responder's `ready`/`op_done` handshake. It sits between bus or test logic and the SPI memory, in the same `clk` domain; no separate serial clock exists.

## Interface
- `TIMEOUT`, 64: handshake watchdog limit in `clk` cycles; only used when `SPI_CTRL_TIMEOUT_EN` is defined.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: command request, sampled only in IDLE.
- `wr` input 1: 1 = write, 0 = read; sampled with `start`.
- `addr` input 5: memory word address, 0..31.
- `wdata` input 8: write data.
- `busy` output 1: command in progress.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 8: last read byte, held until the next read completes.
- `err` output 1: watchdog abort flag, valid with `done`.
- `cs` output 1: active-low chip select to the memory.
- `mosi` output 1: serial data to the memory.
- `ready` input 1: memory has latched the read address.
- `miso` input 1: serial data from the memory.
- `op_done` input 1: memory has finished the operation.

## Operation
- Reset values: `cs`=1, `mosi`=0, `busy`=0, `done`=0, `rdata`=0, `err`=0, state IDLE, all counters 0.
- States: IDLE, SEL, OPC, SHIFT, WAIT_RDY, RECV, WAIT_DONE.
- IDLE:
  - `start`=1 latches `wr`, `{3'b000,addr}` and `wdata` into a 16-bit shift register: bits [7:0] = address, [15:8] = data.
  - Drives `cs`=0, `mosi`=0 and `busy`=1, then moves to SEL.
- SEL → OPC: drives `mosi`=`wr` for one cycle.
- SHIFT: drives one bit per cycle, LSB first.
  - Write: 16 bits (address, then data).
  - Read: 8 address bits.
  - `cs` returns to 1 on the edge that follows the last bit. It must be high before the memory returns to its idle state.
- Write path: SHIFT → WAIT_DONE.
- Read path: SHIFT → WAIT_RDY. When `ready`=1 is sampled, go to RECV. RECV samples `miso` on the next 8 edges into `rdata` bits 0..7, LSB first, then goes to WAIT_DONE.
- WAIT_DONE: when `op_done`=1 is sampled:
  - `done`=1 and `busy`=0.
  - `rdata` is updated (read only).
  - Return to IDLE.
- `start` while `busy`=1 is ignored; no queueing.
- `start` during the `done` cycle is accepted, so back-to-back commands work.
- `ready` or `op_done` arriving in an unexpected state is ignored.
- Reset asserted mid-command: outputs go to reset values immediately, and `cs`=1 asynchronously. The memory's own reset must also be applied by the system.

## Timing
- Edge numbering: the edge that samples `start` is E0.
- `cs` is low from after E0 until after E18 (write) or after E10 (read).
- `mosi` timing:
  - Opcode is valid after E1.
  - Bit k is valid after E(2+k).
  - The memory samples bit k at E(3+k).
- Read handshake:
  - `ready` is sampled high at E12.
  - `miso` bit k is sampled at E(13+k).
  - `op_done` is sampled at E21.
- Write handshake: `op_done` is sampled at E20.
- Latency from the `start` edge to `done` high: write 20 cycles (`done` after E20), read 21 cycles (`done` after E21).
- `busy` is high for the cycles after E0 through the `done` edge, and low in the `done` cycle.

## Configuration
- `SPI_CTRL_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT_RDY and WAIT_DONE.
  - If it reaches `TIMEOUT` without the expected handshake, the block drives `cs`=1, pulses `done` with `err`=1 and returns to IDLE.
  - `rdata` is unchanged on an abort.
  - `err` clears on the next `start`.
- `SPI_CTRL_TIMEOUT_EN` undefined: the block waits indefinitely, and `err` is tied to 0.

## Test plan
- Write `addr`=5, `wdata`=0xA5 → `mosi` sequence 1, then 1,0,1,0,0,0,0,0, then 1,0,1,0,0,1,0,1 → `done` after 20 cycles, `err`=0.
- Read `addr`=5 after that write → `rdata`=0xA5, `done` after 21 cycles, `cs` high after E10.
- Pulse `start` at cycle 5 of an active write with `addr`=9 → ignored; memory location 9 is unchanged; a single `done` pulse occurs.
- Back-to-back commands: write 31/0x3C, `start` read 31 during the `done` cycle → `rdata`=0x3C, no idle gap.
- Assert `rst`=0 at cycle 8 of a read → `cs`=1, `busy`=0 and `done`=0 immediately. After release (memory also reset), a read of address 5 returns 0x00.
- With `SPI_CTRL_TIMEOUT_EN` and `TIMEOUT`=64, hold the memory in reset and issue a read → `done`=1 with `err`=1 exactly 64 cycles after entering WAIT_RDY, `rdata` unchanged.
